instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameters: WORD_WIDTH, default 32, datapath width; RESET_PC, default 0, first fetch address.
REQ-002 SHALL have ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- freeze  input  1  hazard stall from the decode stage.
- branch_taken  input  1  redirect request from the execute stage.
- branch_address  input  WORD_WIDTH  redirect target.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  WORD_WIDTH  fetch address.
- imem_ready  input  1  imem_rdata valid for the current imem_addr.
- imem_rdata  input  WORD_WIDTH  fetched word.
- pc  output  WORD_WIDTH  fetch address + 4 of the delivered instruction (drives decode pc_in).
- instruction  output  WORD_WIDTH  delivered instruction (drives decode instruction_in).
- valid  output  1  pc/instruction hold a real instruction.

Function
REQ-003 SHALL register pc, instruction and valid (IF/ID pipeline register); no combinational path from imem_rdata to these outputs.
REQ-004 SHALL implement FSM states IDLE, FETCH, STALL; IDLE is entered only by reset and lasts exactly one cycle after reset release, then goes to FETCH.
REQ-005 SHALL hold an internal fetch pointer pc_reg; imem_addr = pc_reg at all times.
REQ-006 SHALL drive imem_req = 1 only in FETCH, and 0 in IDLE and STALL.
REQ-007 FETCH, imem_ready=1, freeze=0, branch_taken=0: SHALL load pc <= pc_reg+4, instruction <= imem_rdata, valid <= 1, pc_reg <= pc_reg+4; stay in FETCH.
REQ-008 FETCH, imem_ready=0, freeze=0, branch_taken=0: SHALL load valid <= 0 (bubble), keep pc_reg; pc/instruction values are don't-care-but-held.
REQ-009 FETCH, freeze=1, branch_taken=0: SHALL hold pc, instruction, valid; if imem_ready=1 SHALL capture imem_rdata and pc_reg+4 into a one-entry skid buffer and go to STALL; if imem_ready=0 stay in FETCH.
REQ-010 STALL, freeze=1, branch_taken=0: SHALL hold all outputs, pc_reg and buffer.
REQ-011 STALL, freeze=0, branch_taken=0: SHALL transfer buffer to pc/instruction, valid <= 1, pc_reg <= pc_reg+4, go to FETCH; no re-fetch of the buffered word.
REQ-012 branch_taken=1 in FETCH or STALL SHALL take priority over freeze and imem_ready: pc_reg <= branch_address, pc <= 0, instruction <= 0, valid <= 0, skid buffer discarded, next state FETCH; a same-cycle imem response is discarded.
REQ-013 branch_taken in IDLE SHALL be ignored.
REQ-014 pc_reg+4 SHALL wrap modulo 2^WORD_WIDTH with no flag.
REQ-015 branch_address SHALL be used as given (no alignment masking).

Reset
REQ-016 rst=0 SHALL immediately, without a clock edge, force state IDLE, pc_reg = RESET_PC, pc = 0, instruction = 0, valid = 0, imem_req = 0, buffer cleared.
REQ-017 Reset asserted mid-FETCH or mid-STALL SHALL abandon the in-flight fetch; after release fetching restarts at RESET_PC.

Verification
REQ-018 Bench SHALL cover:
- Reset release, imem_ready=1, freeze=0, memory word(addr)=addr|0xE000_0000 -> imem_addr 0,4,8...; pc/instruction 4/0xE000_0000, 8/0xE000_0004 on consecutive cycles, valid=1.
- imem_ready=0 for 3 cycles at addr 0x8 -> imem_addr held 0x8, valid=0 three cycles, then pc=0xC delivered.
- freeze=1 for 2 cycles with ready=1 at addr 0x10 -> outputs frozen, imem_req=0 in STALL; on release pc=0x14 delivered once, next imem_addr 0x14.
- branch_taken=1, branch_address=0x100 -> next cycle imem_addr=0x100, valid=0; following cycle pc=0x104.
- branch_taken=1 and freeze=1 same cycle in STALL -> buffer dropped, imem_addr=branch_address, valid=0.
- rst=0 asynchronously mid-STALL -> valid, pc, instruction, imem_req 0 before next edge; after release first imem_addr = RESET_PC; pc_reg=0xFFFF_FFFC fetch wraps next address to 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request and fills the IF/ID register.
// A one-entry skid buffer keeps a word that arrives while decode is frozen, so it is never re-fetched.
module instruction_fetch_unit #(
    parameter int unsigned           WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_address,
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic [WORD_WIDTH-1:0] pc,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic                  valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [WORD_WIDTH-1:0] PC_STEP = WORD_WIDTH'(32'd4);

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_reg_q, pc_reg_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic [WORD_WIDTH-1:0] buf_pc_q, buf_pc_d;
    logic [WORD_WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic [WORD_WIDTH-1:0] pc_next_s;
    logic                  redirect_s;

    // Redirects are only honoured once the unit has left IDLE.
    assign redirect_s = branch_taken && (state_q != ST_IDLE);
    assign pc_next_s  = pc_reg_q + PC_STEP;

    // Next-state and IF/ID register update; a redirect overrides freeze and any memory response.
    always_comb begin
        state_d     = state_q;
        pc_reg_d    = pc_reg_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        if (redirect_s) begin
            state_d     = ST_FETCH;
            pc_reg_d    = branch_address;
            pc_d        = '0;
            instr_d     = '0;
            valid_d     = 1'b0;
            buf_pc_d    = '0;
            buf_instr_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (freeze) begin
                        if (imem_ready) begin
                            buf_pc_d    = pc_next_s;
                            buf_instr_d = imem_rdata;
                            state_d     = ST_STALL;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else if (imem_ready) begin
                        pc_d     = pc_next_s;
                        instr_d  = imem_rdata;
                        valid_d  = 1'b1;
                        pc_reg_d = pc_next_s;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                ST_STALL: begin
                    if (freeze) begin
                        state_d = ST_STALL;
                    end else begin
                        pc_d     = buf_pc_q;
                        instr_d  = buf_instr_q;
                        valid_d  = 1'b1;
                        pc_reg_d = pc_next_s;
                        state_d  = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, fetch pointer, IF/ID register and skid buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pc_reg_q    <= RESET_PC;
            pc_q        <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_reg_q    <= pc_reg_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_reg_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized bench for instruction_fetch_unit against a transaction-level fetch model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;

    int total;
    int bad;

    // Model: next address to fetch, delivered slot, and a word held while decode is frozen.
    logic [31:0] m_fetch_addr;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_warmup;
    logic        m_holding;
    logic [31:0] m_hold_word;

    instruction_fetch_unit #(
        .WORD_WIDTH(32),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_address(branch_address),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .instruction   (instruction),
        .valid         (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, (!m_warmup && !m_holding)});
        chk({tag, ".imem_addr"}, imem_addr, m_fetch_addr);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, m_valid});
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".instruction"}, instruction, m_instr);
    endtask

    task automatic model_reset();
        m_fetch_addr = RESET_PC;
        m_pc         = 32'd0;
        m_instr      = 32'd0;
        m_valid      = 1'b0;
        m_warmup     = 1'b1;
        m_holding    = 1'b0;
        m_hold_word  = 32'd0;
    endtask

    // One clock of activity: the memory answers with addr|0xE000_0000 whenever it is ready.
    task automatic cycle(input string tag, input logic fr, input logic br,
                         input logic [31:0] ba, input logic rdy);
        logic [31:0] word;
        word           = imem_addr | 32'hE000_0000;
        freeze         = fr;
        branch_taken   = br;
        branch_address = ba;
        imem_ready     = rdy;
        imem_rdata     = word;
        @(posedge clk);
        if (m_warmup) begin
            m_warmup = 1'b0;
        end else if (br) begin
            m_fetch_addr = ba;
            m_pc = 32'd0; m_instr = 32'd0; m_valid = 1'b0;
            m_holding = 1'b0;
        end else if (m_holding) begin
            if (!fr) begin
                m_fetch_addr = m_fetch_addr + 32'd4;
                m_pc = m_fetch_addr; m_instr = m_hold_word; m_valid = 1'b1;
                m_holding = 1'b0;
            end
        end else if (fr) begin
            if (rdy) begin
                m_holding   = 1'b1;
                m_hold_word = word;
            end
        end else if (rdy) begin
            m_fetch_addr = m_fetch_addr + 32'd4;
            m_pc = m_fetch_addr; m_instr = word; m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Asynchronous reset pulse applied away from the clock edge; effects checked before any edge.
    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        branch_address = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
        model_reset();
        #2;
        check_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        cycle("idle", 1'b0, 1'b0, 32'd0, 1'b1);
        cycle("seq0", 1'b0, 1'b0, 32'd0, 1'b1);
        chk("seq0.pc4", pc, 32'h0000_0004);
        chk("seq0.instr", instruction, 32'hE000_0000);
        cycle("seq1", 1'b0, 1'b0, 32'd0, 1'b1);
        chk("seq1.pc8", pc, 32'h0000_0008);

        repeat (3) cycle("bubble", 1'b0, 1'b0, 32'd0, 1'b0);
        chk("bubble.addr", imem_addr, 32'h0000_0008);
        cycle("after_bubble", 1'b0, 1'b0, 32'd0, 1'b1);
        chk("after_bubble.pc", pc, 32'h0000_000C);
        cycle("to_0x10", 1'b0, 1'b0, 32'd0, 1'b1);

        cycle("freeze0", 1'b1, 1'b0, 32'd0, 1'b1);
        cycle("freeze1", 1'b1, 1'b0, 32'd0, 1'b1);
        chk("stall.req", {31'd0, imem_req}, 32'd0);
        cycle("unfreeze", 1'b0, 1'b0, 32'd0, 1'b1);
        chk("unfreeze.pc", pc, 32'h0000_0014);
        chk("unfreeze.addr", imem_addr, 32'h0000_0014);
        cycle("post_unfreeze", 1'b0, 1'b0, 32'd0, 1'b1);

        cycle("branch", 1'b0, 1'b1, 32'h0000_0100, 1'b1);
        chk("branch.addr", imem_addr, 32'h0000_0100);
        cycle("branch_tgt", 1'b0, 1'b1 & 1'b0, 32'd0, 1'b1);
        chk("branch_tgt.pc", pc, 32'h0000_0104);

        cycle("stall_br0", 1'b1, 1'b0, 32'd0, 1'b1);
        cycle("stall_br1", 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        chk("stall_br.addr", imem_addr, 32'h0000_0200);
        cycle("stall_br2", 1'b0, 1'b0, 32'd0, 1'b1);

        cycle("pre_rst", 1'b1, 1'b0, 32'd0, 1'b1);
        pulse_reset("rst_stall");
        cycle("idle_br", 1'b0, 1'b1, 32'h0000_0300, 1'b1);
        chk("idle_br.addr", imem_addr, RESET_PC);
        cycle("restart", 1'b0, 1'b0, 32'd0, 1'b1);

        cycle("wrap_br", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle("wrap", 1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap.pc", pc, 32'h0000_0000);
        chk("wrap.instr", instruction, 32'hFFFF_FFFC);
        chk("wrap.addr", imem_addr, 32'h0000_0000);

        for (int i = 0; i < 600; i++) begin
            logic        fr, br, rdy;
            logic [31:0] ba;
            fr  = ($urandom_range(0, 99) < 30);
            br  = ($urandom_range(0, 99) < 8);
            rdy = ($urandom_range(0, 99) < 70);
            ba  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : $urandom();
            if ($urandom_range(0, 149) == 0) begin
                pulse_reset("rand_rst");
            end else begin
                cycle("rand", fr, br, ba, rdy);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
